tick_period_meter: RTL

Receiving end of the tick pulses our clock dividers produce. It measures the number of `inclk` cycles between successive rising edges of a pulse input and hands each measurement downstream over a valid/ready handshake. It also flags lost pulses (timeout) and dropped measurements (overrun). It sits beside the divider in the top level and is used to check divider ratios on hardware and to qualify external tick sources.

---
 rtl/tick_meter_pkg.sv | 13 +
 rtl/pulse_sync_edge.sv | 26 ++
 rtl/tick_period_meter.sv | 107 ++++++++++
 3 files changed

// File: rtl/tick_meter_pkg.sv
// Shared types and default constants for the tick period meter and its helpers.
package tick_meter_pkg;

  typedef enum logic {
    IDLE,
    MEASURE
  } meter_state_t;

  localparam int unsigned          TM_WIDTH       = 20;
  localparam logic [TM_WIDTH-1:0]  TM_TIMEOUT     = 20'hFFFFF;
  localparam int unsigned          TM_SYNC_STAGES = 2;

endpackage

// File: rtl/pulse_sync_edge.sv
// N-stage synchronizer for an asynchronous pulse followed by a one-cycle rising-edge detector.
module pulse_sync_edge #(
  parameter int unsigned STAGES = 2
) (
  input  logic inclk,
  input  logic rst_n,
  input  logic async_in,
  output logic rise
);

  logic [STAGES-1:0] sync_q;
  logic              prev_q;

  always_ff @(posedge inclk) begin
    if (!rst_n) begin
      sync_q <= '0;
      prev_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[STAGES-2:0], async_in};
      prev_q <= sync_q[STAGES-1];
    end
  end

  assign rise = sync_q[STAGES-1] & ~prev_q;

endmodule

// File: rtl/tick_period_meter.sv
// Measures inclk cycles between rising edges of pulse_in and offers each period over valid/ready,
// flagging lost pulses (timeout) and measurements dropped under backpressure (overrun).
module tick_period_meter
  import tick_meter_pkg::*;
#(
  parameter int unsigned      WIDTH       = TM_WIDTH,
  parameter logic [WIDTH-1:0] TIMEOUT     = WIDTH'(TM_TIMEOUT),
  parameter int unsigned      SYNC_STAGES = TM_SYNC_STAGES
) (
  input  logic             inclk,
  input  logic             rst_n,
  input  logic             pulse_in,
  output logic [WIDTH-1:0] period,
  output logic             period_valid,
  input  logic             period_ready,
  output logic             timeout,
  output logic             overrun
);

  meter_state_t     state_q, state_d;
  logic [WIDTH-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] period_q, period_d;
  logic             valid_q, valid_d;
  logic             timeout_q, timeout_d;
  logic             overrun_q, overrun_d;
  logic             rise;
  logic             capture;

  pulse_sync_edge #(
    .STAGES(SYNC_STAGES)
  ) u_sync (
    .inclk   (inclk),
    .rst_n   (rst_n),
    .async_in(pulse_in),
    .rise    (rise)
  );

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    period_d  = period_q;
    valid_d   = valid_q;
    timeout_d = timeout_q;
    overrun_d = overrun_q;
    capture   = 1'b0;

    unique case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (rise) begin
          cnt_d     = WIDTH'(1);
          state_d   = MEASURE;
          timeout_d = 1'b0;
        end
      end
      MEASURE: begin
        // An edge on the terminal-count cycle is a normal capture, not a timeout.
        if (rise) begin
          capture = 1'b1;
          cnt_d   = WIDTH'(1);
        end else if (cnt_q == TIMEOUT) begin
          timeout_d = 1'b1;
          cnt_d     = '0;
          state_d   = IDLE;
        end else begin
          cnt_d = cnt_q + WIDTH'(1);
        end
      end
      default: state_d = IDLE;
    endcase

    if (capture) begin
      if (!valid_q || period_ready) begin
        period_d = cnt_q;
        valid_d  = 1'b1;
      end else begin
        overrun_d = 1'b1;
      end
    end else if (valid_q && period_ready) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge inclk) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      period_q  <= '0;
      valid_q   <= 1'b0;
      timeout_q <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      period_q  <= period_d;
      valid_q   <= valid_d;
      timeout_q <= timeout_d;
      overrun_q <= overrun_d;
    end
  end

  assign period       = period_q;
  assign period_valid = valid_q;
  assign timeout      = timeout_q;
  assign overrun      = overrun_q;

endmodule
